// File: rtl/cp0_pkg.sv
// cp0_pkg: shared definitions for the coprocessor-0 block.
//  - CP0 register numbers used by MTC0/MFC0
//  - ExcCode values understood by the pipeline
//  - Status/Cause field bit positions, writable masks and reset constants
//  - helper that classifies address-error exception codes
package cp0_pkg;

  localparam logic [4:0] REG_BADVADDR = 5'd8;
  localparam logic [4:0] REG_COUNT    = 5'd9;
  localparam logic [4:0] REG_COMPARE  = 5'd11;
  localparam logic [4:0] REG_STATUS   = 5'd12;
  localparam logic [4:0] REG_CAUSE    = 5'd13;
  localparam logic [4:0] REG_EPC      = 5'd14;
  localparam logic [4:0] REG_PRID     = 5'd15;
  localparam logic [4:0] REG_CONFIG   = 5'd16;

  typedef enum logic [4:0] {
    EXC_INT  = 5'd0,
    EXC_ADEL = 5'd4,
    EXC_ADES = 5'd5,
    EXC_SYS  = 5'd8,
    EXC_RI   = 5'd10,
    EXC_OV   = 5'd12
  } exc_code_e;

  localparam int STATUS_IE     = 0;
  localparam int STATUS_EXL    = 1;
  localparam int STATUS_IM_LSB = 8;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_IP_LSB  = 8;
  localparam int CAUSE_WP      = 22;
  localparam int CAUSE_IV      = 23;
  localparam int CAUSE_BD      = 31;

  localparam logic [31:0] STATUS_RST   = 32'h1000_0000;
  // Bits 27:23 of Status are reserved and always read 0.
  localparam logic [31:0] STATUS_WMASK = 32'hF07F_FFFF;
  localparam logic [31:0] CONFIG_VAL   = 32'h0000_8000;
  localparam logic [31:0] VECTOR_OFS   = 32'h0000_0180;

  // True for the address-error codes that capture BadVAddr.
  function automatic logic is_addr_exc(input logic [4:0] code);
    return (code == EXC_ADEL) || (code == EXC_ADES);
  endfunction

endpackage

// File: rtl/cp0_timer.sv
// cp0_timer: Count/Compare timer with sticky match flag.
// Ports:
//  clk, rst_n     clock, asynchronous active-low reset
//  count_we       MTC0 Count this cycle (wins over increment)
//  compare_we     MTC0 Compare this cycle (also clears the flag)
//  wdata          write data, TIMER_W bits
//  count/compare  current register values
//  timer_int      sticky timer interrupt flag
module cp0_timer #(
  parameter int TIMER_W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               count_we,
  input  logic               compare_we,
  input  logic [TIMER_W-1:0] wdata,
  output logic [TIMER_W-1:0] count,
  output logic [TIMER_W-1:0] compare,
  output logic               timer_int
);

  localparam logic [TIMER_W-1:0] ONE  = {{(TIMER_W-1){1'b0}}, 1'b1};
  localparam logic [TIMER_W-1:0] ZERO = {TIMER_W{1'b0}};

  logic [TIMER_W-1:0] count_r;
  logic [TIMER_W-1:0] compare_r;
  logic               timer_int_r;
  logic               match_s;

  // A Compare of zero never raises the timer interrupt.
  assign match_s = (count_r == compare_r) && (compare_r != ZERO);

  // Count/Compare registers and sticky match flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r     <= ZERO;
      compare_r   <= ZERO;
      timer_int_r <= 1'b0;
    end else begin
      if (count_we) begin
        count_r <= wdata;
      end else begin
        count_r <= count_r + ONE;
      end
      if (compare_we) begin
        compare_r <= wdata;
      end else begin
        compare_r <= compare_r;
      end
      // Writing Compare acknowledges the interrupt, even on a same-cycle match.
      if (compare_we) begin
        timer_int_r <= 1'b0;
      end else if (match_s) begin
        timer_int_r <= 1'b1;
      end else begin
        timer_int_r <= timer_int_r;
      end
    end
  end

  assign count     = count_r;
  assign compare   = compare_r;
  assign timer_int = timer_int_r;

endmodule

// File: rtl/cp0_ctrl.sv
// cp0_ctrl: MIPS coprocessor-0 (Count/Compare, Status, Cause, EPC, PRId, Config),
// precise exception entry / ERET return and masked interrupt detection.
// Ports:
//  clk, rst_n                     clock, asynchronous active-low reset
//  we_i/waddr_i/wdata_i           MTC0 write
//  raddr_i/rdata_o                MFC0 read (combinational, old value on same-cycle write)
//  int_i                          level-sensitive hardware interrupts -> Cause.IP[2+:NUM_HW_INT]
//  exc_req_i/exc_code_i/exc_pc_i/exc_bd_i  exception request from MEM
//  eret_i                         ERET retiring
//  int_pending_o                  enabled, unmasked interrupt present
//  redirect_o/redirect_pc_o       registered 1-cycle redirect and its target
//  status_o/cause_o/epc_o         current register values
//  timer_int_o                    timer interrupt flag (also Cause.IP[7])
// Optional feature: define CP0_BADVADDR_EN to add badvaddr_i and the BadVAddr register.
module cp0_ctrl
  import cp0_pkg::*;
#(
  parameter int          NUM_HW_INT = 6,
  parameter int          TIMER_W    = 32,
  parameter logic [31:0] EXC_BASE   = 32'hBFC00200,
  parameter logic [31:0] PRID_VAL   = 32'h004C0102
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we_i,
  input  logic [4:0]            waddr_i,
  input  logic [31:0]           wdata_i,
  input  logic [4:0]            raddr_i,
  output logic [31:0]           rdata_o,
  input  logic [NUM_HW_INT-1:0] int_i,
  input  logic                  exc_req_i,
  input  logic [4:0]            exc_code_i,
  input  logic [31:0]           exc_pc_i,
  input  logic                  exc_bd_i,
  input  logic                  eret_i,
  output logic                  int_pending_o,
  output logic                  redirect_o,
  output logic [31:0]           redirect_pc_o,
  output logic [31:0]           status_o,
  output logic [31:0]           cause_o,
  output logic [31:0]           epc_o,
  output logic                  timer_int_o
`ifdef CP0_BADVADDR_EN
  ,
  input  logic [31:0]           badvaddr_i
`endif
);

  logic [31:0]           status_r, status_n_s;
  logic [31:0]           epc_r, epc_n_s;
  logic                  bd_r, bd_n_s;
  logic [4:0]            exc_code_r;
  logic                  iv_r, wp_r;
  logic [1:0]            ip_sw_r;
  logic [NUM_HW_INT-1:0] ip_hw_r;
  logic                  redirect_r;
  logic [31:0]           redirect_pc_r;
  logic [TIMER_W-1:0]    count_s, compare_s;
  logic                  timer_int_s;
  logic [7:0]            ip_s;
  logic [31:0]           cause_s, count_ext_s, compare_ext_s;
  logic                  wr_status_s, wr_cause_s, wr_epc_s;
`ifdef CP0_BADVADDR_EN
  logic [31:0]           badvaddr_r;
`endif

  assign wr_status_s = we_i && (waddr_i == REG_STATUS);
  assign wr_cause_s  = we_i && (waddr_i == REG_CAUSE);
  assign wr_epc_s    = we_i && (waddr_i == REG_EPC);

  cp0_timer #(.TIMER_W(TIMER_W)) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .count_we   (we_i && (waddr_i == REG_COUNT)),
    .compare_we (we_i && (waddr_i == REG_COMPARE)),
    .wdata      (wdata_i[TIMER_W-1:0]),
    .count      (count_s),
    .compare    (compare_s),
    .timer_int  (timer_int_s)
  );

  // Status next value: MTC0 first, then exception/ERET override EXL only.
  always_comb begin
    status_n_s = status_r;
    if (wr_status_s) begin
      status_n_s = wdata_i & STATUS_WMASK;
    end else begin
      status_n_s = status_r;
    end
    status_n_s[STATUS_EXL] = exc_req_i ? 1'b1 : (eret_i ? 1'b0 : status_n_s[STATUS_EXL]);
  end

  // EPC/BD next value: captured only on a first-level exception (EXL clear).
  always_comb begin
    epc_n_s = epc_r;
    bd_n_s  = bd_r;
    if (exc_req_i && !status_r[STATUS_EXL]) begin
      epc_n_s = exc_bd_i ? (exc_pc_i - 32'd4) : exc_pc_i;
      bd_n_s  = exc_bd_i;
    end else if (wr_epc_s) begin
      epc_n_s = wdata_i;
      bd_n_s  = bd_r;
    end else begin
      epc_n_s = epc_r;
      bd_n_s  = bd_r;
    end
  end

  // Architectural CP0 state and the registered redirect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      status_r      <= STATUS_RST;
      epc_r         <= 32'd0;
      bd_r          <= 1'b0;
      exc_code_r    <= 5'd0;
      iv_r          <= 1'b0;
      wp_r          <= 1'b0;
      ip_sw_r       <= 2'b00;
      ip_hw_r       <= {NUM_HW_INT{1'b0}};
      redirect_r    <= 1'b0;
      redirect_pc_r <= 32'd0;
    end else begin
      status_r   <= status_n_s;
      epc_r      <= epc_n_s;
      bd_r       <= bd_n_s;
      exc_code_r <= exc_req_i ? exc_code_i : exc_code_r;
      ip_hw_r    <= int_i;
      if (wr_cause_s) begin
        iv_r    <= wdata_i[CAUSE_IV];
        wp_r    <= wdata_i[CAUSE_WP];
        ip_sw_r <= wdata_i[CAUSE_IP_LSB +: 2];
      end else begin
        iv_r    <= iv_r;
        wp_r    <= wp_r;
        ip_sw_r <= ip_sw_r;
      end
      redirect_r <= exc_req_i || eret_i;
      // ERET returns to the EPC held before this cycle's update.
      if (exc_req_i) begin
        redirect_pc_r <= EXC_BASE + VECTOR_OFS;
      end else if (eret_i) begin
        redirect_pc_r <= epc_r;
      end else begin
        redirect_pc_r <= redirect_pc_r;
      end
    end
  end

`ifdef CP0_BADVADDR_EN
  // BadVAddr is captured on address-error exceptions only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      badvaddr_r <= 32'd0;
    end else if (exc_req_i && is_addr_exc(exc_code_i)) begin
      badvaddr_r <= badvaddr_i;
    end else begin
      badvaddr_r <= badvaddr_r;
    end
  end
`endif

  // Cause assembly; with six hardware lines the timer shares IP[7] with int_i[5].
  always_comb begin
    ip_s = 8'd0;
    ip_s[2 +: NUM_HW_INT] = ip_hw_r;
    ip_s[7]   = ip_s[7] | timer_int_s;
    ip_s[1:0] = ip_sw_r;
    cause_s = 32'd0;
    cause_s[CAUSE_BD] = bd_r;
    cause_s[CAUSE_IV] = iv_r;
    cause_s[CAUSE_WP] = wp_r;
    cause_s[CAUSE_IP_LSB +: 8] = ip_s;
    cause_s[CAUSE_EXC_LSB +: 5] = exc_code_r;
    count_ext_s = 32'd0;
    count_ext_s[TIMER_W-1:0] = count_s;
    compare_ext_s = 32'd0;
    compare_ext_s[TIMER_W-1:0] = compare_s;
  end

  // MFC0 read mux; unmapped register numbers read zero.
  always_comb begin
    rdata_o = 32'd0;
    case (raddr_i)
      REG_COUNT:    rdata_o = count_ext_s;
      REG_COMPARE:  rdata_o = compare_ext_s;
      REG_STATUS:   rdata_o = status_r;
      REG_CAUSE:    rdata_o = cause_s;
      REG_EPC:      rdata_o = epc_r;
      REG_PRID:     rdata_o = PRID_VAL;
      REG_CONFIG:   rdata_o = CONFIG_VAL;
`ifdef CP0_BADVADDR_EN
      REG_BADVADDR: rdata_o = badvaddr_r;
`else
      REG_BADVADDR: rdata_o = 32'd0;
`endif
      default:      rdata_o = 32'd0;
    endcase
  end

  assign int_pending_o = status_r[STATUS_IE] & ~status_r[STATUS_EXL] &
                         (|(ip_s & status_r[STATUS_IM_LSB +: 8]));
  assign redirect_o    = redirect_r;
  assign redirect_pc_o = redirect_pc_r;
  assign status_o      = status_r;
  assign cause_o       = cause_s;
  assign epc_o         = epc_r;
  assign timer_int_o   = timer_int_s;

endmodule
